// File: rtl/lstx_q.sv
// Queued local synchronous transmitter.
// A DEPTH-entry write FIFO feeds a serial shifter clocked by uclk, which is either
// fclk directly or fclk divided by (div+1) per half-period. Frames run back to back
// while words remain queued. push, clear, fclk and uclk are toggle events: each edge
// of either polarity is one event, detected against a registered copy.
module lstx_q #(
  parameter int unsigned DMSB = 9,
  parameter int unsigned BMSB = 3,
  parameter int unsigned CMSB = 12,
  parameter int unsigned AMSB = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            setn,
  input  logic            push,
  input  logic            clear,
  input  logic [DMSB:0]   wdata,
  input  logic [BMSB:0]   nbit,
  input  logic            msb_first,
  input  logic            idle_lvl,
  input  logic [CMSB:0]   div,
  input  logic            fclk,
  input  logic            sel_fclk,
  output logic            tx,
  output logic            full,
  output logic            empty,
  output logic [AMSB+1:0] level,
  output logic            ovf,
  output logic [1:0]      cst,
  output logic [1:0]      nst,
  output logic            xst
);

  localparam int unsigned     Depth     = 1 << (AMSB + 1);
  localparam logic [AMSB+1:0] LevelFull = (AMSB + 2)'(Depth);
  localparam logic [BMSB:0]   NbitMax   = (BMSB + 1)'(DMSB);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StClear = 2'b01,
    StCnt   = 2'b10,
    StLoad  = 2'b11
  } state_e;

  // Event-detect copies of the toggle sources
  logic push_q, clear_q, fclk_q, uclk_ev_q;

  // FIFO
  logic [DMSB:0]   mem_q [Depth];
  logic [AMSB:0]   wptr_q, wptr_d;
  logic [AMSB:0]   rptr_q, rptr_d;
  logic [AMSB+1:0] level_q, level_d;
  logic            ovf_q, ovf_d;
  logic            wr_en;

  // Divider and shifter
  logic [CMSB:0]   cnt_q, cnt_d;
  logic            uclk_div_q, uclk_div_d;
  logic [BMSB:0]   bth_q, bth_d;
  logic [DMSB:0]   shreg_q, shreg_d;

  // Control
  state_e          cst_q, nst_s;
  logic            xst_q;
  // Low only between reset release and the first enabled clock; holds tx at 0 there
  logic            run_q;

  logic            push_x, clear_x, fclk_x, uclk_x, uclk_src;
  logic            fifo_ne, pop;
  logic [BMSB:0]   nb_eff;
  logic [DMSB:0]   head, head_rev;

  assign push_x   = push ^ push_q;
  assign clear_x  = clear ^ clear_q;
  assign fclk_x   = fclk ^ fclk_q;
  assign uclk_src = sel_fclk ? fclk : uclk_div_q;
  assign uclk_x   = uclk_src ^ uclk_ev_q;

  assign fifo_ne  = (level_q != '0);
  assign full     = (level_q == LevelFull);
  assign nb_eff   = (nbit > NbitMax) ? NbitMax : nbit;
  assign head     = mem_q[rptr_q];

  // Mirror the head word over bits 0..nb_eff; bits above the frame are never shown on tx
  always_comb begin
    head_rev = head;
    for (int i = 0; i <= DMSB; i++) begin
      for (int k = 0; k <= DMSB; k++) begin
        if (int'(nb_eff) == i + k) head_rev[i] = head[k];
      end
    end
  end

  // Next-state decode; every datapath update below is keyed on nst
  always_comb begin
    nst_s = cst_q;
    case (cst_q)
      StIdle: begin
        if (clear_x)      nst_s = StClear;
        else if (fifo_ne) nst_s = StLoad;
      end
      StLoad:  nst_s = StCnt;
      StCnt: begin
        if (clear_x)                         nst_s = StClear;
        else if (uclk_x && (bth_q == '0))    nst_s = fifo_ne ? StLoad : StIdle;
      end
      StClear: nst_s = StIdle;
      default: nst_s = StIdle;
    endcase
  end

  // Datapath next values: FIFO pointers/level, divider and shifter
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    uclk_div_d = uclk_div_q;
    bth_d      = bth_q;
    shreg_d    = shreg_q;
    wr_en      = 1'b0;
    pop        = 1'b0;

    if (nst_s == StClear) begin
      // Clear wins over a same-cycle push; that word is discarded
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      ovf_d      = 1'b0;
      cnt_d      = '0;
      uclk_div_d = 1'b0;
    end else begin
      if (push_x) begin
        if (!full) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end

      if (nst_s == StLoad) begin
        pop     = 1'b1;
        rptr_d  = rptr_q + 1'b1;
        shreg_d = msb_first ? head_rev : head;
        bth_d   = nb_eff;
        cnt_d   = div;
      end

      level_d = level_q + (AMSB + 2)'(wr_en) - (AMSB + 2)'(pop);

      if (nst_s == StCnt) begin
        if (fclk_x) begin
          if (cnt_q == '0) begin
            cnt_d      = div;
            uclk_div_d = ~uclk_div_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        if (uclk_x) begin
          shreg_d = {idle_lvl, shreg_q[DMSB:1]};
          bth_d   = bth_q - 1'b1;
        end
      end
    end
  end

  // State, event-detect and datapath registers; everything holds while setn is low
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      push_q     <= 1'b0;
      clear_q    <= 1'b0;
      fclk_q     <= 1'b0;
      uclk_ev_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      uclk_div_q <= 1'b0;
      bth_q      <= '0;
      shreg_q    <= '0;
      cst_q      <= StIdle;
      xst_q      <= 1'b0;
      run_q      <= 1'b0;
    end else if (setn) begin
      push_q     <= push;
      clear_q    <= clear;
      fclk_q     <= fclk;
      uclk_ev_q  <= uclk_src;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      uclk_div_q <= uclk_div_d;
      bth_q      <= bth_d;
      shreg_q    <= shreg_d;
      cst_q      <= nst_s;
      xst_q      <= (nst_s != cst_q);
      run_q      <= 1'b1;
    end
  end

  // FIFO storage; no reset needed since level gates every read
  always_ff @(posedge clk) begin
    if (setn && wr_en) mem_q[wptr_q] <= wdata;
  end

  // Line drive: shifter LSB during a frame, idle level otherwise
  always_comb begin
    tx = 1'b0;
    if (run_q) begin
      tx = ((cst_q == StLoad) || (cst_q == StCnt)) ? shreg_q[0] : idle_lvl;
    end
  end

  assign empty = (level_q == '0) && (cst_q == StIdle);
  assign level = level_q;
  assign ovf   = ovf_q;
  assign cst   = cst_q;
  assign nst   = nst_s;
  assign xst   = xst_q;

endmodule
